// File: rtl/proc_run_sequencer.sv
// Run controller for the single-cycle core: walks a program table,
// drives core reset/start PC, and scores each program's pass code.
module proc_run_sequencer #(
  parameter int NUM_PROGS   = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int WDOG_MAX    = 511
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_idx,
  input  logic [63:0]          cfg_start_pc,
  input  logic [63:0]          cfg_end_pc,
  input  logic [63:0]          cfg_expect,
  input  logic                 cfg_do_reset,
  input  logic                 go,
  output logic                 proc_reset_l,
  output logic [63:0]          proc_start_pc,
  input  logic [63:0]          currentPC,
  input  logic [63:0]          dMemOut,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           pass_count,
  output logic [NUM_PROGS-1:0] fail_vec,
  output logic                 timeout
);

  localparam int IW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW = $clog2(WDOG_MAX + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PROGS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LIM  = WW'(WDOG_MAX);
  localparam logic [4:0]    NP        = 5'(NUM_PROGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nidx;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic rst_l_q, rst_l_d;
  logic [63:0] spc_q, spc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [7:0] pass_q, pass_d;
  logic [NUM_PROGS-1:0] fail_q, fail_d;
  logic tmo_q, tmo_d;
  logic tbl_we;

  // Table storage survives Reset so a rerun needs no reprogramming
  logic [63:0] start_pc_q [NUM_PROGS];
  logic [63:0] end_pc_q   [NUM_PROGS];
  logic [63:0] expect_q   [NUM_PROGS];
  logic [NUM_PROGS-1:0] do_reset_q;

  always_ff @(posedge CLK) begin
    if (tbl_we) begin
      start_pc_q[cfg_idx[IW-1:0]] <= cfg_start_pc;
      end_pc_q[cfg_idx[IW-1:0]]   <= cfg_end_pc;
      expect_q[cfg_idx[IW-1:0]]   <= cfg_expect;
      do_reset_q[cfg_idx[IW-1:0]] <= cfg_do_reset;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    wdog_d  = wdog_q;
    rst_l_d = rst_l_q;
    spc_d   = spc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    tbl_we  = 1'b0;
    nidx    = idx_q + 1'b1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        tbl_we = cfg_we && ({1'b0, cfg_idx} < NP);
        if (go) begin
          pass_d = 8'd0;
          fail_d = '0;
          tmo_d  = 1'b0;
          idx_d  = '0;
          hold_d = '0;
          wdog_d = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          if (do_reset_q[0]) begin
            state_d = S_HOLD;
            rst_l_d = 1'b0;
            spc_d   = start_pc_q[0];
          end else begin
            state_d = S_RUN;
            rst_l_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          rst_l_d = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        wdog_d = wdog_q + 1'b1;
        if (currentPC >= end_pc_q[idx_q]) begin
          state_d = S_SETTLE;
        end else if (wdog_q == WDOG_LIM) begin
          wdog_d        = wdog_q;
          tmo_d         = 1'b1;
          fail_d[idx_q] = 1'b1;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (dMemOut == expect_q[idx_q]) begin
          if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
        end else begin
          fail_d[idx_q] = 1'b1;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        wdog_d = '0;
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = nidx;
          if (do_reset_q[nidx]) begin
            state_d = S_HOLD;
            rst_l_d = 1'b0;
            spc_d   = start_pc_q[nidx];
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      wdog_q  <= '0;
      rst_l_q <= 1'b0;
      spc_q   <= 64'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 8'd0;
      fail_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      wdog_q  <= wdog_d;
      rst_l_q <= rst_l_d;
      spc_q   <= spc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  assign proc_reset_l  = rst_l_q;
  assign proc_start_pc = spc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass_count    = pass_q;
  assign fail_vec      = fail_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_proc_run_sequencer.sv
// Directed bench for proc_run_sequencer with a PC+4 core model.
module tb_proc_run_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset, cfg_we, cfg_do_reset, go, freeze;
  logic [3:0] cfg_idx;
  logic [63:0] cfg_start_pc, cfg_end_pc, cfg_expect;
  logic [63:0] pc, d0, d1, dmem;

  logic rst_l, busy, done, tmo;
  logic [63:0] spc;
  logic [7:0] pass;
  logic [1:0] fail;

  logic rst_l4, busy4, done4, tmo4;
  logic [63:0] spc4;
  logic [7:0] pass4;
  logic [1:0] fail4;

  int n_vec = 0;
  int n_err = 0;
  int low;
  int cnt;

  localparam logic [63:0] EXP1 = 64'h1234_5678_9abc_def0;

  proc_run_sequencer #(
    .NUM_PROGS(2), .HOLD_CYCLES(1), .WDOG_MAX(511)
  ) u_dut (
    .CLK(CLK), .Reset(Reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start_pc(cfg_start_pc), .cfg_end_pc(cfg_end_pc),
    .cfg_expect(cfg_expect), .cfg_do_reset(cfg_do_reset), .go(go),
    .proc_reset_l(rst_l), .proc_start_pc(spc), .currentPC(pc),
    .dMemOut(dmem), .busy(busy), .done(done), .pass_count(pass),
    .fail_vec(fail), .timeout(tmo)
  );

  proc_run_sequencer #(
    .NUM_PROGS(2), .HOLD_CYCLES(4), .WDOG_MAX(511)
  ) u_dut4 (
    .CLK(CLK), .Reset(Reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start_pc(cfg_start_pc), .cfg_end_pc(cfg_end_pc),
    .cfg_expect(cfg_expect), .cfg_do_reset(cfg_do_reset), .go(go),
    .proc_reset_l(rst_l4), .proc_start_pc(spc4), .currentPC(pc),
    .dMemOut(dmem), .busy(busy4), .done(done4), .pass_count(pass4),
    .fail_vec(fail4), .timeout(tmo4)
  );

  // Core model: load start PC in reset, else step by 4
  always @(posedge CLK) begin
    if (freeze) pc <= 64'h10;
    else if (!rst_l) pc <= spc;
    else pc <= pc + 64'd4;
  end

  assign dmem = (pc < 64'h50) ? d0 : d1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] i, input logic [63:0] s,
                    input logic [63:0] e, input logic [63:0] x,
                    input logic r);
    cfg_idx = i;
    cfg_start_pc = s;
    cfg_end_pc = e;
    cfg_expect = x;
    cfg_do_reset = r;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic kick();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic run_done(input int budget);
    low = 0;
    for (int k = 0; k < budget; k++) begin
      if (done) break;
      if (busy && !rst_l) low++;
      tick();
    end
    chk("done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    Reset = 1'b1;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_start_pc = '0;
    cfg_end_pc = '0;
    cfg_expect = '0;
    cfg_do_reset = 1'b0;
    go = 1'b0;
    freeze = 1'b0;
    pc = '0;
    d0 = 64'hF;
    d1 = EXP1;
    tick();
    tick();
    chk("rst_reset_l", {63'd0, rst_l}, 64'd0);
    chk("rst_spc", spc, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {56'd0, pass}, 64'd0);
    chk("rst_fail", {62'd0, fail}, 64'd0);
    chk("rst_tmo", {63'd0, tmo}, 64'd0);
    Reset = 1'b0;
    tick();

    wr(4'd0, 64'h0, 64'h30, 64'hF, 1'b1);
    wr(4'd1, 64'h0, 64'h60, EXP1, 1'b0);

    // both entries pass
    kick();
    chk("t1_busy_c1", {63'd0, busy}, 64'd1);
    chk("t1_rl_c1", {63'd0, rst_l}, 64'd0);
    run_done(200);
    chk("t1_low_cycles", 64'(low), 64'd1);
    chk("t1_pass", {56'd0, pass}, 64'd2);
    chk("t1_fail", {62'd0, fail}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_tmo", {63'd0, tmo}, 64'd0);

    // first check mismatches, second still runs
    d0 = 64'hE;
    kick();
    run_done(200);
    chk("t2_pass", {56'd0, pass}, 64'd1);
    chk("t2_fail", {62'd0, fail}, 64'd1);
    d0 = 64'hF;

    // frozen PC trips the watchdog and aborts
    freeze = 1'b1;
    kick();
    run_done(700);
    chk("t3_tmo", {63'd0, tmo}, 64'd1);
    chk("t3_fail", {62'd0, fail}, 64'd1);
    chk("t3_pass", {56'd0, pass}, 64'd0);
    freeze = 1'b0;

    // four-cycle hold on the second instance
    pulse_reset();
    wr(4'd0, 64'h40, 64'h30, 64'hF, 1'b1);
    kick();
    chk("t4_spc", spc4, 64'h40);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (rst_l4) break;
      cnt++;
      tick();
    end
    chk("t4_low_cycles", 64'(cnt), 64'd4);
    chk("t4_rl_rise", {63'd0, rst_l4}, 64'd1);
    chk("t4_spc_hold", spc4, 64'h40);
    pulse_reset();
    wr(4'd0, 64'h0, 64'h30, 64'hF, 1'b1);

    // Reset mid-run, then rerun
    kick();
    for (int k = 0; k < 100; k++) begin
      if (pass == 8'd1) break;
      tick();
    end
    tick();
    tick();
    tick();
    chk("t5_busy_pre", {63'd0, busy}, 64'd1);
    chk("t5_pass_pre", {56'd0, pass}, 64'd1);
    pulse_reset();
    chk("t5_rl", {63'd0, rst_l}, 64'd0);
    chk("t5_spc", spc, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_done", {63'd0, done}, 64'd0);
    chk("t5_pass", {56'd0, pass}, 64'd0);
    chk("t5_fail", {62'd0, fail}, 64'd0);
    chk("t5_tmo", {63'd0, tmo}, 64'd0);
    kick();
    run_done(200);
    chk("t5_rerun_pass", {56'd0, pass}, 64'd2);
    chk("t5_rerun_fail", {62'd0, fail}, 64'd0);

    // cfg write and go while busy are ignored
    kick();
    tick();
    tick();
    go = 1'b1;
    wr(4'd0, 64'h0, 64'h0, 64'hBAD, 1'b0);
    go = 1'b0;
    run_done(200);
    chk("t6_pass", {56'd0, pass}, 64'd2);
    chk("t6_fail", {62'd0, fail}, 64'd0);

    // out-of-range index is ignored; go in DONE restarts
    wr(4'd3, 64'h0, 64'h0, 64'hBAD, 1'b1);
    kick();
    chk("t6_restart_pass", {56'd0, pass}, 64'd0);
    chk("t6_restart_done", {63'd0, done}, 64'd0);
    chk("t6_restart_busy", {63'd0, busy}, 64'd1);
    run_done(200);
    chk("t6_rerun_pass", {56'd0, pass}, 64'd2);
    chk("t6_rerun_fail", {62'd0, fail}, 64'd0);
    chk("t6_rerun_tmo", {63'd0, tmo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
